// File: rtl/csa64bit_sub_seq.sv
// Multi-cycle 64-bit subtractor: diff = a - b, SLICE_W bits per clock from the
// least-significant slice up, with a rippled borrow register between slices.
module csa64bit_sub_seq #(
  parameter int SLICE_W = 16,
  parameter int NSLICE  = 64 / SLICE_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] diff,
  output logic        b_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  generate
    if (!(SLICE_W == 8 || SLICE_W == 16 || SLICE_W == 32 || SLICE_W == 64) ||
        (NSLICE * SLICE_W != 64)) begin : g_bad_slice_w
      $error("csa64bit_sub_seq: SLICE_W must be 8, 16, 32 or 64 and NSLICE = 64/SLICE_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [63:0]     a_r, b_r;
  logic [IDXW-1:0] idx;
  logic            br;
  logic [SLICE_W:0] slice_sum;

  // a + ~b + ~br: top bit is the inverted borrow out of this slice
  always_comb begin
    slice_sum = {1'b0, a_r[idx*SLICE_W +: SLICE_W]}
              + {1'b0, ~b_r[idx*SLICE_W +: SLICE_W]}
              + {{SLICE_W{1'b0}}, ~br};
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      idx       <= '0;
      br        <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          idx   <= '0;
          br    <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          diff[idx*SLICE_W +: SLICE_W] <= slice_sum[SLICE_W-1:0];
          br <= ~slice_sum[SLICE_W];
          if (idx == IDX_LAST) begin
            b_out     <= ~slice_sum[SLICE_W];
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa64bit_sub_seq.sv
// Bench for csa64bit_sub_seq: three instances (SLICE_W 16, 8, 64), directed
// corner cases on the default width, then random adder round-trips on all.
module tb_csa64bit_sub_seq;

  localparam int NINST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] a = '0, b = '0;
  logic [NINST-1:0] in_valid = '0, out_ready = '0;
  logic [NINST-1:0] in_ready, out_valid, b_out;
  logic [NINST-1:0][63:0] diff;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int sw_of(input int k);
    return (k == 0) ? 16 : (k == 1) ? 8 : 64;
  endfunction

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    csa64bit_sub_seq #(.SLICE_W(sw_of(g))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .diff     (diff[g]),
      .b_out    (b_out[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: 65-bit subtraction, top bit is the borrow
  function automatic logic [64:0] ref_sub(input logic [63:0] x, input logic [63:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int k, input logic [63:0] x, input logic [63:0] y);
    chk("in_ready_idle", 64'(in_ready[k]), 64'd1);
    a = x;
    b = y;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; checks in_ready stays low
  task automatic wait_done(input int k);
    int lat = 0;
    while (!out_valid[k] && lat < 20) begin
      chk("in_ready_busy", 64'(in_ready[k]), 64'd0);
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(64 / sw_of(k)));
    chk("in_ready_done", 64'(in_ready[k]), 64'd0);
  endtask

  task automatic release_out(input int k);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic op_check(input int k, input string tag, input logic [63:0] x, input logic [63:0] y);
    logic [64:0] r = ref_sub(x, y);
    start(k, x, y);
    wait_done(k);
    chk({tag, "_diff"}, diff[k], r[63:0]);
    chk({tag, "_bout"}, 64'(b_out[k]), 64'(r[64]));
    release_out(k);
  endtask

  initial begin
    logic [64:0] r1, r2;
    tick();
    tick();
    rst = 1'b0;

    for (int k = 0; k < NINST; k++) begin
      chk("rst_in_ready", 64'(in_ready[k]), 64'd1);
      chk("rst_out_valid", 64'(out_valid[k]), 64'd0);
      chk("rst_diff", diff[k], 64'd0);
      chk("rst_bout", 64'(b_out[k]), 64'd0);
    end

    op_check(0, "10m3", 64'd10, 64'd3);
    op_check(0, "0m1", 64'd0, 64'd1);
    op_check(0, "xslice", 64'h0000_0000_0001_0000, 64'd1);
    op_check(0, "eq", 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);

    // Backpressure: result held, new operands ignored until released
    r1 = ref_sub(64'd20, 64'd5);
    r2 = ref_sub(64'h1234_0000_0000_0000, 64'h0000_0000_0000_0042);
    start(0, 64'd20, 64'd5);
    wait_done(0);
    a = 64'h1234_0000_0000_0000;
    b = 64'h0000_0000_0000_0042;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_diff", diff[0], r1[63:0]);
      chk("hold_bout", 64'(b_out[0]), 64'(r1[64]));
      chk("hold_valid", 64'(out_valid[0]), 64'd1);
      chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("rel_valid", 64'(out_valid[0]), 64'd0);
    chk("rel_in_ready", 64'(in_ready[0]), 64'd1);
    chk("rel_diff_kept", diff[0], r1[63:0]);
    tick();
    in_valid[0] = 1'b0;
    wait_done(0);
    chk("next_diff", diff[0], r2[63:0]);
    chk("next_bout", 64'(b_out[0]), 64'(r2[64]));
    release_out(0);

    // Reset on the second CALC cycle discards the operation
    start(0, 64'd100, 64'd7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("mid_rst_diff", diff[0], 64'd0);
    chk("mid_rst_bout", 64'(b_out[0]), 64'd0);
    op_check(0, "5m9", 64'd5, 64'd9);

    // Round trip: s = x + y on the adder model, then s - y must return x with borrow == carry
    for (int k = 0; k < NINST; k++) begin
      for (int n = 0; n < 1000; n++) begin
        logic [63:0] x, y, s;
        logic        co;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        case ($urandom_range(0, 5))
          0: x = '0;
          1: y = '1;
          2: x = '1;
          3: y = 64'($urandom_range(0, 3));
          default: ;
        endcase
        {co, s} = {1'b0, x} + {1'b0, y};
        start(k, s, y);
        wait_done(k);
        chk("rt_diff", diff[k], x);
        chk("rt_bout", 64'(b_out[k]), 64'(co));
        release_out(k);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csa64bit_sub_seq.md
# csa64bit_sub_seq

Multi-cycle 64-bit subtractor, the inverse-direction companion to the 64-bit adder model: it recovers an operand from a sum (`diff = a - b`) and reports borrow. It processes `SLICE_W` bits per clock from least-significant slice upward, with a ripple borrow register between slices. Operands enter and results leave on valid/ready handshakes. It sits downstream of the adder datapath and round-trip checking logic.

## Interface
- `SLICE_W`, default 16: bits subtracted per cycle. Legal values are 8, 16, 32 or 64.
- `NSLICE`, default 64/SLICE_W: derived from `SLICE_W`. Do not override.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `a`  in  64  minuend; sampled on the input handshake.
- `b`  in  64  subtrahend; sampled on the input handshake.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept operands. High only in IDLE.
- `diff`  out  64  `(a - b) mod 2^64`; registered.
- `b_out`  out  1  borrow out; 1 iff `a < b` unsigned; registered.
- `out_valid`  out  1  `diff` and `b_out` are valid.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- States are IDLE, CALC and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: latch `a` and `b`, clear slice counter `idx` to 0, set borrow register `br` = 0, go to CALC.
- **CALC**
  - Each cycle computes `{c, d} = a[idx] + ~b[idx] + ~br` over `SLICE_W` bits, where `[idx]` means slice `idx*SLICE_W +: SLICE_W`.
  - Writes `d` into `diff[idx]` and sets `br = ~c`.
  - Increments `idx`.
  - On the edge processing `idx == NSLICE-1`: set `b_out = ~c`, set `out_valid = 1`, go to DONE.
- **DONE**
  - `diff`, `b_out` and `out_valid` hold stable while `out_ready` = 0.
  - On `out_valid && out_ready`: clear `out_valid`, go to IDLE. `diff` and `b_out` retain their values.
- Width rules:
  - All arithmetic is unsigned modulo 2^64.
  - The internal slice adder is `SLICE_W+1` bits wide. Its top bit is the inverted borrow.
  - No carry-in port; the initial borrow is always 0.
- While `in_ready` = 0, `in_valid` and the operand inputs are ignored. No operand is queued.
- Only 64 % SLICE_W == 0 is supported. Any other value is illegal and must be caught by an elaboration-time check.

## Timing
- Reset values, in the cycle after an edge where `rst` = 1:
  - state = IDLE, `in_ready` = 1.
  - `out_valid` = 0.
  - `diff` = 0, `b_out` = 0.
  - `idx` = 0, `br` = 0.
- Latency:
  - Input handshake at edge T.
  - Slices are computed on edges T+1 … T+NSLICE.
  - `out_valid` is high in the cycle following edge T+NSLICE. With the default this is 4 cycles after acceptance.
- Throughput: one operation per NSLICE+2 cycles at best, because IDLE always lasts at least one cycle after an output handshake. There is no same-cycle accept on output release.
- `in_ready` is a pure decode of state and has no combinational path from `in_valid`. `out_valid` is a register.
- Reset mid-operation (in CALC or DONE):
  - The current operation is discarded.
  - All outputs take their reset values on that edge.
  - No partial result is ever presented.
- Reset has priority over every handshake on the same edge.
- `a == b` yields `diff` = 0 and `b_out` = 0.
- Borrow propagates across all slice boundaries, including a full chain of ones across every slice.

## Test plan
- Accept `a`=10, `b`=3 → after 4 cycles `out_valid`=1, `diff`=7, `b_out`=0. `in_ready`=0 throughout CALC and DONE.
- Accept `a`=0, `b`=1 → `diff`=0xFFFF_FFFF_FFFF_FFFF, `b_out`=1. This checks borrow ripple through all 4 slices.
- Accept `a`=0x0000_0000_0001_0000, `b`=1 → `diff`=0x0000_0000_0000_FFFF, `b_out`=0. This checks a single cross-slice borrow.
- Complete one op, then hold `out_ready`=0 for 10 cycles while driving `in_valid`=1 with new operands.
  - Required: `diff`, `b_out` and `out_valid` stay stable.
  - Required: the new operands are not captured.
  - After `out_ready`=1 → IDLE for 1 cycle, then the new pair is accepted.
- Assert `rst` for one cycle on the 2nd CALC cycle → the next cycle shows `out_valid`=0, `in_ready`=1, `diff`=0. A following `a`=5, `b`=9 gives `diff`=0xFFFF_FFFF_FFFF_FFFC, `b_out`=1.
- Random round-trip check, 1000 pairs: compute `s = (x + y) mod 2^64` on the adder model, then subtract `y` → `diff` == `x`. `b_out` equals the adder's carry-out. Rerun with `SLICE_W` = 8 and 64.
